j1x_core: RTL and testbench

//  Parametrised successor J1 stack CPU core: configurable data width, stack

---
 rtl/j1x_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_j1x_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/j1x_core.sv
// j1x_core: parametrised J1-family stack CPU core.
//
// Purpose:
//   Executes J1 instructions fetched from a synchronous-read code RAM.
//   The core adds an interrupt request/acknowledge handshake gated by a
//   software enable bit, sticky overflow/underflow flags for both stacks,
//   and an extended ALU space selected by insn[12]=1 on ALU instructions.
//
// Parameters:
//   WIDTH   data path / stack cell width (must exceed AW)
//   AW      code address width; pc[AW-1]=1 marks a data-fetch cycle
//   DDEPTH  data stack depth (power of 2, >= 4)
//   RDEPTH  return stack depth (power of 2, >= 4)
//   VEC     interrupt vector (code word address)
//
// Ports:
//   clk        clock, all state on posedge
//   reset      synchronous, active-high
//   code_addr  next pc, to the synchronous-read code RAM
//   insn       code RAM data, valid one cycle after code_addr
//   mem_addr   data memory / IO address (T)
//   dout       data memory / IO write data (N)
//   mem_wr     data memory write strobe
//   io_wr      IO write strobe
//   io_rd      IO read strobe
//   io_din     IO read data, sampled in the io_rd cycle
//   irq_req    level interrupt request
//   irq_ack    one-cycle pulse in the cycle the interrupt is taken
//   dstk_err   sticky {overflow, underflow} of the data stack
//   rstk_err   sticky {overflow, underflow} of the return stack
//
// Configuration:
//   J1X_MUL_EN  when defined, extended op 0 computes T <= T*N (low WIDTH
//               bits) in one cycle; otherwise extended op 0 leaves T alone.

module j1x_core #(
    parameter int unsigned   WIDTH  = 16,
    parameter int unsigned   AW     = 13,
    parameter int unsigned   DDEPTH = 16,
    parameter int unsigned   RDEPTH = 16,
    parameter logic [AW-1:0] VEC    = 13'h1FFE
) (
    input  logic             clk,
    input  logic             reset,
    output logic [AW-1:0]    code_addr,
    input  logic [15:0]      insn,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] dout,
    output logic             mem_wr,
    output logic             io_wr,
    output logic             io_rd,
    input  logic [WIDTH-1:0] io_din,
    input  logic             irq_req,
    output logic             irq_ack,
    output logic [1:0]       dstk_err,
    output logic [1:0]       rstk_err
);

    localparam int unsigned DW = $clog2(DDEPTH);
    localparam int unsigned RW = $clog2(RDEPTH);

    typedef enum logic [3:0] {
        A_T     = 4'h0,
        A_N     = 4'h1,
        A_ADD   = 4'h2,
        A_AND   = 4'h3,
        A_OR    = 4'h4,
        A_XOR   = 4'h5,
        A_INV   = 4'h6,
        A_EQ    = 4'h7,
        A_LT    = 4'h8,
        A_SRA   = 4'h9,
        A_SHL   = 4'hA,
        A_R     = 4'hB,
        A_SUB   = 4'hC,
        A_IO    = 4'hD,
        A_DEPTH = 4'hE,
        A_ULT   = 4'hF
    } alu_op_e;

    typedef enum logic [3:0] {
        X_MUL  = 4'h0,
        X_EINT = 4'h1,
        X_DINT = 4'h2
    } ext_op_e;

    typedef enum logic [2:0] {
        F_NONE = 3'd0,
        F_TN   = 3'd1,
        F_TR   = 3'd2,
        F_MEMW = 3'd3,
        F_IOW  = 3'd4,
        F_IOR  = 3'd5
    } field_e;

    // architectural state
    logic             booted;
    logic [AW-1:0]    pc;
    logic [WIDTH-1:0] st0;
    logic [DW-1:0]    dsp;
    logic [RW-1:0]    rsp;
    logic             ie;
    logic [1:0]       derr;
    logic [1:0]       rerr;

    logic [WIDTH-1:0] dstack [DDEPTH];
    logic [WIDTH-1:0] rstack [RDEPTH];

    // decode results
    logic [WIDTH-1:0] st1;
    logic [WIDTH-1:0] rst0;
    logic [WIDTH-1:0] st0_n;
    logic [AW-1:0]    pc_n;
    logic [AW-1:0]    pc_plus;
    logic [AW-1:0]    target;
    logic [1:0]       dsp_d;
    logic [1:0]       rsp_d;
    logic [DW-1:0]    dsp_n;
    logic [RW-1:0]    rsp_n;
    logic             dstk_w;
    logic             rstk_w;
    logic [WIDTH-1:0] rstk_d;
    logic             ie_n;
    logic             mem_wr_c;
    logic             io_wr_c;
    logic             io_rd_c;
    logic             run;
    logic             take;
    logic [WIDTH:0]   minus;
    logic             signed_lt;
    logic             d_ovf;
    logic             d_unf;
    logic             r_ovf;
    logic             r_unf;
    alu_op_e          aop;

    assign run     = booted & ~reset;
    assign take    = run & ie & irq_req & ~pc[AW-1];
    assign st1     = dstack[dsp];
    assign rst0    = rstack[rsp];
    assign pc_plus = pc + AW'(1);
    assign target  = AW'(insn[12:0]);
    assign aop     = alu_op_e'(insn[11:8]);

    // minus = N - T with a borrow bit; bit WIDTH set means N < T unsigned
    assign minus     = {1'b0, st1} - {1'b0, st0};
    assign signed_lt = (st0[WIDTH-1] ^ st1[WIDTH-1]) ? st1[WIDTH-1] : minus[WIDTH];

    always_comb begin
        st0_n    = st0;
        pc_n     = pc_plus;
        dsp_d    = 2'b00;
        rsp_d    = 2'b00;
        dstk_w   = 1'b0;
        rstk_w   = 1'b0;
        rstk_d   = st0;
        ie_n     = ie;
        mem_wr_c = 1'b0;
        io_wr_c  = 1'b0;
        io_rd_c  = 1'b0;

        if (take) begin
            // fetched insn is dropped and re-fetched after return
            rstk_w = 1'b1;
            rsp_d  = 2'b01;
            rstk_d = WIDTH'({pc, 1'b0});
            pc_n   = VEC;
            ie_n   = 1'b0;
        end else if (pc[AW-1]) begin
            // data fetch: push the code word, return to caller
            st0_n  = WIDTH'(insn);
            dstk_w = 1'b1;
            dsp_d  = 2'b01;
            rsp_d  = 2'b11;
            pc_n   = rst0[AW:1];
        end else begin
            casez (insn[15:13])
                3'b1??: begin
                    st0_n  = WIDTH'(insn[14:0]);
                    dstk_w = 1'b1;
                    dsp_d  = 2'b01;
                end
                3'b000: pc_n = target;
                3'b001: begin
                    st0_n = st1;
                    dsp_d = 2'b11;
                    if (st0 == '0) pc_n = target;
                end
                3'b010: begin
                    rstk_w = 1'b1;
                    rsp_d  = 2'b01;
                    rstk_d = WIDTH'({pc_plus, 1'b0});
                    pc_n   = target;
                end
                default: begin
                    if (insn[12]) begin
`ifdef J1X_MUL_EN
                        if (insn[11:8] == X_MUL) st0_n = st0 * st1;
`endif
                        if (insn[11:8] == X_EINT) ie_n = 1'b1;
                        if (insn[11:8] == X_DINT) ie_n = 1'b0;
                    end else begin
                        case (aop)
                            A_T:     st0_n = st0;
                            A_N:     st0_n = st1;
                            A_ADD:   st0_n = st0 + st1;
                            A_AND:   st0_n = st0 & st1;
                            A_OR:    st0_n = st0 | st1;
                            A_XOR:   st0_n = st0 ^ st1;
                            A_INV:   st0_n = ~st0;
                            A_EQ:    st0_n = {WIDTH{minus[WIDTH-1:0] == '0}};
                            A_LT:    st0_n = {WIDTH{signed_lt}};
                            A_SRA:   st0_n = {st0[WIDTH-1], st0[WIDTH-1:1]};
                            A_SHL:   st0_n = {st0[WIDTH-2:0], 1'b0};
                            A_R:     st0_n = rst0;
                            A_SUB:   st0_n = minus[WIDTH-1:0];
                            A_IO:    st0_n = io_din;
                            A_DEPTH: st0_n = WIDTH'(dsp);
                            A_ULT:   st0_n = {WIDTH{minus[WIDTH]}};
                            default: st0_n = st0;
                        endcase
                    end
                    dstk_w   = (insn[6:4] == F_TN);
                    rstk_w   = (insn[6:4] == F_TR);
                    mem_wr_c = (insn[6:4] == F_MEMW);
                    io_wr_c  = (insn[6:4] == F_IOW);
                    io_rd_c  = (insn[6:4] == F_IOR);
                    dsp_d    = insn[1:0];
                    rsp_d    = insn[3:2];
                    if (insn[7]) pc_n = rst0[AW:1];
                end
            endcase
        end
    end

    assign dsp_n = dsp + DW'($signed(dsp_d));
    assign rsp_n = rsp + RW'($signed(rsp_d));

    assign d_ovf = (dsp_d == 2'b01) && (dsp == '1);
    assign d_unf = dsp_d[1] && ((dsp_d == 2'b11) ? (dsp == '0) : (dsp <= DW'(1)));
    assign r_ovf = (rsp_d == 2'b01) && (rsp == '1);
    assign r_unf = rsp_d[1] && ((rsp_d == 2'b11) ? (rsp == '0) : (rsp <= RW'(1)));

    // strobes are gated combinationally so reset silences them immediately
    assign code_addr = run ? pc_n : '0;
    assign mem_wr    = run & mem_wr_c;
    assign io_wr     = run & io_wr_c;
    assign io_rd     = run & io_rd_c;
    assign irq_ack   = take;
    assign mem_addr  = st0;
    assign dout      = st1;
    assign dstk_err  = derr;
    assign rstk_err  = rerr;

    always_ff @(posedge clk) begin
        if (reset) begin
            booted <= 1'b0;
            pc     <= '0;
            st0    <= '0;
            dsp    <= '0;
            rsp    <= '0;
            ie     <= 1'b0;
            derr   <= '0;
            rerr   <= '0;
        end else begin
            booted <= 1'b1;
            pc     <= code_addr;
            if (booted) begin
                st0  <= st0_n;
                dsp  <= dsp_n;
                rsp  <= rsp_n;
                ie   <= ie_n;
                derr <= derr | {d_ovf, d_unf};
                rerr <= rerr | {r_ovf, r_unf};
            end
        end
    end

    // a push combined with T->N is a single write of T at the new slot
    always_ff @(posedge clk) begin
        if (run && dstk_w) dstack[dsp_n] <= st0;
        if (run && rstk_w) rstack[rsp_n] <= rstk_d;
    end

endmodule

// File: tb/tb_j1x_core.sv
module tb_j1x_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] code_addr;
    logic [15:0] insn;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic        mem_wr;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] io_din;
    logic        irq_req;
    logic        irq_ack;
    logic [1:0]  dstk_err;
    logic [1:0]  rstk_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] code [0:4095];

    j1x_core #(
        .WIDTH (16),
        .AW    (13),
        .DDEPTH(16),
        .RDEPTH(16),
        .VEC   (13'h0100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .code_addr(code_addr),
        .insn     (insn),
        .mem_addr (mem_addr),
        .dout     (dout),
        .mem_wr   (mem_wr),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .io_din   (io_din),
        .irq_req  (irq_req),
        .irq_ack  (irq_ack),
        .dstk_err (dstk_err),
        .rstk_err (rstk_err)
    );

    always #5 clk = ~clk;

    // synchronous-read code RAM; the top address bit only selects data fetch
    always @(posedge clk) insn <= code[code_addr[11:0]];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_code();
        for (int i = 0; i < 4096; i++) code[i] = 16'h6000;
    endtask

    // leaves the bench at a negedge with reset low and the core not yet booted
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {28'd0, mem_wr, io_wr, io_rd, irq_ack}, 32'd0);
        chk("rst_st0", {16'd0, mem_addr}, 32'd0);
        reset = 1'b0;
    endtask

    logic [15:0] exp_mul;

    initial begin
        reset   = 1'b1;
        irq_req = 1'b0;
        io_din  = 16'h5A5A;

        // ---- reset release and basic ALU ----
        clear_code();
        code[0]  = 16'h9234;  // lit 1234
        code[1]  = 16'h8FFF;  // lit 0FFF
        code[2]  = 16'h6203;  // +
        code[3]  = 16'h8001;  // lit 1
        code[4]  = 16'h8002;  // lit 2
        code[5]  = 16'h6C03;  // -
        code[6]  = 16'h8002;  // lit 2
        code[7]  = 16'h8000;  // lit 0
        code[8]  = 16'h6600;  // invert
        code[9]  = 16'h6803;  // <
        code[10] = 16'h8002;  // lit 2
        code[11] = 16'h8000;  // lit 0
        code[12] = 16'h6600;  // invert
        code[13] = 16'h6F03;  // u<
        code[14] = 16'h6E11;  // depth
        code[15] = 16'h000F;  // jump 15
        do_reset();
        chk("boot_addr0", {19'd0, code_addr}, 32'd0);
        chk("boot_strobes", {28'd0, mem_wr, io_wr, io_rd, irq_ack}, 32'd0);
        tick();
        chk("boot_addr1", {19'd0, code_addr}, 32'd1);
        tick(3);
        chk("alu_add", {16'd0, mem_addr}, 32'h2233);
        tick(3);
        chk("alu_sub", {16'd0, mem_addr}, 32'hFFFF);
        tick(4);
        chk("alu_slt", {16'd0, mem_addr}, 32'h0000);
        tick(4);
        chk("alu_ult", {16'd0, mem_addr}, 32'hFFFF);
        tick();
        chk("alu_depth", {16'd0, mem_addr}, 32'd4);
        chk("alu_depth_n", {16'd0, dout}, 32'hFFFF);

        // ---- interrupt ----
        clear_code();
        code[0]      = 16'h7100;  // EINT
        code[1]      = 16'h0040;  // jump 0x040
        code[13'h40] = 16'h6000;  // nop
        code[13'h41] = 16'h0041;  // jump self
        code[13'h100] = 16'h6B11; // R@ (push R)
        code[13'h101] = 16'h618F; // drop, exit
        do_reset();
        tick();
        chk("irq_none_eint", {31'd0, irq_ack}, 32'd0);
        tick();
        chk("irq_jump_40", {19'd0, code_addr}, 32'h040);
        tick();
        irq_req = 1'b1;
        #1;
        chk("irq_ack_pulse", {31'd0, irq_ack}, 32'd1);
        chk("irq_vec", {19'd0, code_addr}, 32'h100);
        tick();
        chk("irq_ack_once", {31'd0, irq_ack}, 32'd0);
        chk("irq_isr_next", {19'd0, code_addr}, 32'h101);
        tick();
        chk("irq_ret_addr", {16'd0, mem_addr}, 32'h0080);
        chk("irq_exit", {19'd0, code_addr}, 32'h040);
        tick();
        chk("irq_resume", {19'd0, code_addr}, 32'h041);
        chk("irq_ie_off", {31'd0, irq_ack}, 32'd0);
        chk("irq_rstk_ok", {30'd0, rstk_err}, 32'd0);
        irq_req = 1'b0;

        // ---- stack overflow / underflow ----
        clear_code();
        for (int i = 0; i < 17; i++) code[i] = 16'h8001 + 16'(i);
        code[17] = 16'h600C;  // rdrop on empty return stack
        code[18] = 16'h6E11;  // depth
        code[19] = 16'h0013;  // jump 19
        do_reset();
        tick(16);
        chk("dstk_15_push", {30'd0, dstk_err}, 32'd0);
        tick();
        chk("dstk_16_push", {30'd0, dstk_err}, 32'b10);
        tick();
        chk("dstk_17_push", {30'd0, dstk_err}, 32'b10);
        tick();
        chk("rstk_unf", {30'd0, rstk_err}, 32'b01);
        tick();
        chk("dsp_wrap", {16'd0, mem_addr}, 32'd1);
        tick(5);
        chk("dstk_sticky", {30'd0, dstk_err}, 32'b10);
        chk("rstk_sticky", {30'd0, rstk_err}, 32'b01);
        reset = 1'b1;
        tick();
        chk("err_clear", {28'd0, dstk_err, rstk_err}, 32'd0);

        // ---- data fetch and IO read ----
        clear_code();
        code[0]       = 16'h5200;  // call 0x1200 (data fetch of word 0x200)
        code[1]       = 16'h8055;  // lit 55
        code[2]       = 16'h6D50;  // io@
        code[3]       = 16'h0003;  // jump 3
        code[12'h200] = 16'hBEEF;
        do_reset();
        tick();
        chk("df_call", {19'd0, code_addr}, 32'h1200);
        tick();
        chk("df_return", {19'd0, code_addr}, 32'h0001);
        tick();
        chk("df_word", {16'd0, mem_addr}, 32'hBEEF);
        tick();
        chk("io_rd_pulse", {31'd0, io_rd}, 32'd1);
        chk("io_rd_addr", {16'd0, mem_addr}, 32'h0055);
        tick();
        chk("io_rd_done", {31'd0, io_rd}, 32'd0);
        chk("io_rd_data", {16'd0, mem_addr}, 32'h5A5A);
        chk("io_rd_n", {16'd0, dout}, 32'hBEEF);
        chk("df_rstk_ok", {30'd0, rstk_err}, 32'd0);

        // ---- extended op 0, write strobes, reset mid-instruction ----
        clear_code();
        code[0] = 16'h8123;  // lit 0123
        code[1] = 16'h8100;  // lit 0100
        code[2] = 16'h7000;  // ext op 0
        code[3] = 16'h6030;  // mem write
        code[4] = 16'h6040;  // io write
        code[5] = 16'h6040;  // io write
        code[6] = 16'h0006;  // jump 6
`ifdef J1X_MUL_EN
        exp_mul = 16'h2300;
`else
        exp_mul = 16'h0100;
`endif
        do_reset();
        tick(4);
        chk("ext_op0", {16'd0, mem_addr}, {16'd0, exp_mul});
        chk("ext_op0_n", {16'd0, dout}, 32'h0123);
        chk("mem_wr_pulse", {30'd0, mem_wr, io_wr}, 32'b10);
        tick();
        chk("io_wr_pulse", {30'd0, mem_wr, io_wr}, 32'b01);
        tick();
        chk("io_wr_again", {31'd0, io_wr}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_gate_iowr", {31'd0, io_wr}, 32'd0);
        chk("rst_gate_addr", {19'd0, code_addr}, 32'd0);
        tick();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
